cpu_ctrl: RTL

Instruction-sequencing controller for the 8-bit accumulator CPU. It runs an 8-state loop per instruction (fetch, decode, execute, write-back) and drives the datapath control strobes: PC increment/load, instruction register load, accumulator load, memory read/write and data-bus drive enable. It sits between the clock generator's `fetch` output and the datapath: PC, IR, ALU/accumulator, memory and data bus.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_ctrl_if.sv | 45 ++++
 rtl/cpu_ctrl_decode.sv | 57 +++++
 rtl/cpu_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU controller: opcode constants,
// one-hot state encoding and the packed control-strobe bundle.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [9:0] {
    S_IDLE = 10'b00_0000_0001,
    S_F0   = 10'b00_0000_0010,
    S_F1   = 10'b00_0000_0100,
    S_D0   = 10'b00_0000_1000,
    S_D1   = 10'b00_0001_0000,
    S_E0   = 10'b00_0010_0000,
    S_E1   = 10'b00_0100_0000,
    S_E2   = 10'b00_1000_0000,
    S_WB   = 10'b01_0000_0000,
    S_HALT = 10'b10_0000_0000
  } state_t;

  typedef struct packed {
    logic halt;
    logic datactl_ena;
    logic wr;
    logic rd;
    logic load_acc;
    logic load_ir;
    logic load_pc;
    logic inc_pc;
  } ctrl_out_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Controller <-> datapath signal bundle. The master side (datapath / clock
// generator) drives fetch, opcode and zero; the slave side (controller)
// drives the strobes. There is no handshake: every signal is a level that is
// sampled or held per cycle, opcode is only looked at in D0 and zero only in
// D1. instr_done/retired exist only when CPU_CTRL_TRACE_EN is defined.
interface cpu_ctrl_if #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
);
  logic            fetch;
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            inc_pc;
  logic            load_pc;
  logic            load_ir;
  logic            load_acc;
  logic            rd;
  logic            wr;
  logic            datactl_ena;
  logic            halt;
`ifdef CPU_CTRL_TRACE_EN
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    output fetch, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt,
    input  instr_done, retired
  );
  modport slave (
    input  fetch, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt,
    output instr_done, retired
  );
`else
  modport master (
    output fetch, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );
  modport slave (
    input  fetch, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );
`endif
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Pure combinational strobe decode: given a state and the opcode / zero flag
// that will be held in that state, produce the control strobes for it.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  state_t          st,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  output ctrl_out_t       outs
);

  logic is_alu;
  logic is_sto;
  logic is_jmp;
  logic is_skz;

  // Classify the opcode and decode per-state strobes.
  always_comb begin
    is_alu = (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_AND)) ||
             (op == OP_W'(OP_XOR)) || (op == OP_W'(OP_LDA));
    is_sto = (op == OP_W'(OP_STO));
    is_jmp = (op == OP_W'(OP_JMP));
    is_skz = (op == OP_W'(OP_SKZ));
    outs   = '0;
    case (st)
      S_F0: begin
        outs.rd      = 1'b1;
        outs.load_ir = 1'b1;
      end
      S_F1: begin
        outs.rd      = 1'b1;
        outs.load_ir = 1'b1;
        outs.inc_pc  = 1'b1;
      end
      S_E0: begin
        outs.rd          = is_alu;
        outs.datactl_ena = is_sto;
        outs.load_pc     = is_jmp;
        outs.inc_pc      = is_skz && zero;
      end
      S_E1: begin
        outs.rd          = is_alu;
        outs.load_acc    = is_alu;
        outs.datactl_ena = is_sto;
        outs.wr          = is_sto;
        outs.load_pc     = is_jmp;
      end
      S_E2: outs.datactl_ena = is_sto;
      S_WB: outs.inc_pc = !is_jmp;
      S_HALT: outs.halt = 1'b1;
      default: outs = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction-sequencing controller: 8-state loop per instruction, registered
// datapath strobes. Optional trace (instr_done pulse, retired counter) is
// built when CPU_CTRL_TRACE_EN is defined.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  cpu_ctrl_if.slave   bus,
  output state_t      dbg_state
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            zero_q, zero_d;
  ctrl_out_t       out_q, out_d;

  // Next state plus the opcode/zero values that will be held after the edge;
  // the strobes are decoded from those so they are valid on state entry.
  always_comb begin
    state_d = S_IDLE;
    op_d    = (state_q == S_D0) ? bus.opcode : op_q;
    zero_d  = (state_q == S_D1) ? bus.zero : zero_q;
    case (state_q)
      S_IDLE: state_d = bus.fetch ? S_F0 : S_IDLE;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_D0;
      S_D0:   state_d = S_D1;
      S_D1:   state_d = (op_q == OP_W'(OP_HLT)) ? S_HALT : S_E0;
      S_E0:   state_d = S_E1;
      S_E1:   state_d = S_E2;
      S_E2:   state_d = S_WB;
      S_WB:   state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  cpu_ctrl_decode #(.OP_W(OP_W)) u_decode (
    .st   (state_d),
    .op   (op_d),
    .zero (zero_d),
    .outs (out_d)
  );

  // State, captured operands and registered strobes; reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      zero_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      out_q   <= out_d;
    end
  end

  assign bus.inc_pc      = out_q.inc_pc;
  assign bus.load_pc     = out_q.load_pc;
  assign bus.load_ir     = out_q.load_ir;
  assign bus.load_acc    = out_q.load_acc;
  assign bus.rd          = out_q.rd;
  assign bus.wr          = out_q.wr;
  assign bus.datactl_ena = out_q.datactl_ena;
  assign bus.halt        = out_q.halt;
  assign dbg_state       = state_q;

`ifdef CPU_CTRL_TRACE_EN
  logic             instr_done_q;
  logic [CNT_W-1:0] retired_q;

  // WB pulse registered on entry; counter bumps on the edge leaving WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_done_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      instr_done_q <= (state_d == S_WB);
      if (state_q == S_WB) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.instr_done = instr_done_q;
  assign bus.retired    = retired_q;
`endif

endmodule
